// File: rtl/puf_response_reader_if.sv
// -----------------------------------------------------------------------------
// puf_response_reader_if
//   Bundles the signals of the arbiter-PUF readout controller.
//   Host side : start, seed_challenge (to reader); busy, done, response (back).
//   Fabric side: challenge, launch, arb_clr (to delay chain); arb_in (back).
//   modport slave  : the readout controller itself.
//   modport master : whoever drives requests and models the PUF fabric.
// -----------------------------------------------------------------------------
interface puf_response_reader_if #(
    parameter int CHAL_W = 32,
    parameter int RESP_W = 8
);
    logic              start;
    logic [CHAL_W-1:0] seed_challenge;
    logic              busy;
    logic              done;
    logic [RESP_W-1:0] response;
    logic [CHAL_W-1:0] challenge;
    logic              launch;
    logic              arb_clr;
    logic              arb_in;

    modport slave (
        input  start, seed_challenge, arb_in,
        output busy, done, response, challenge, launch, arb_clr
    );

    modport master (
        output start, seed_challenge, arb_in,
        input  busy, done, response, challenge, launch, arb_clr
    );
endinterface

// File: rtl/puf_response_reader.sv
// -----------------------------------------------------------------------------
// puf_response_reader
//   Readout controller for an arbiter-PUF mux delay chain. For every response
//   bit it runs VOTES evaluations (clear arbiter, launch, settle, sample) and
//   majority-votes the synchronized arbiter decisions. Voted bits are shifted
//   into the response word MSB-first; the challenge rotates left by one
//   between bits.
//
// Parameters
//   CHAL_W  challenge width (mux stages), >= 2
//   RESP_W  response bits per request, >= 2
//   VOTES   evaluations per bit, odd and >= 1
//   SETTLE  cycles launch is held before sampling, >= 3
//
// Ports
//   clk, rst_n  system clock, asynchronous active-low reset
//   bus         puf_response_reader_if.slave:
//                 start/seed_challenge in, busy/done/response out (host),
//                 challenge/launch/arb_clr out, arb_in in (PUF fabric)
// -----------------------------------------------------------------------------
module puf_response_reader #(
    parameter int CHAL_W = 32,
    parameter int RESP_W = 8,
    parameter int VOTES  = 5,
    parameter int SETTLE = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    puf_response_reader_if.slave    bus
);

    localparam int VW = $clog2(VOTES + 1);
    localparam int BW = $clog2(RESP_W + 1);
    localparam int SW = $clog2(SETTLE);

    localparam logic [VW-1:0] VOTE_LAST   = VW'(VOTES - 1);
    localparam logic [VW-1:0] VOTE_HALF   = VW'(VOTES / 2);
    localparam logic [BW-1:0] BIT_LAST    = BW'(RESP_W - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LAUNCH,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DECIDE,
        ST_DONE
    } state_t;

    state_t            state;
    logic [VW-1:0]     ones;
    logic [VW-1:0]     vote_cnt;
    logic [BW-1:0]     bit_cnt;
    logic [SW-1:0]     settle_cnt;
    logic [1:0]        arb_sync;

    logic              busy_q;
    logic              done_q;
    logic              launch_q;
    logic              arb_clr_q;
    logic [RESP_W-1:0] response_q;
    logic [CHAL_W-1:0] challenge_q;

    logic              vote_bit;

    // VOTES is odd, so a strict majority always exists.
    assign vote_bit = (ones > VOTE_HALF);

    // arb_in is asynchronous to clk; two flops resolve metastability before the
    // value is used. SETTLE >= 3 guarantees the decision has crossed both.
    // NOTE: sequential state uses non-blocking assignments so every flop sees the
    // pre-edge value of every other flop, whatever the statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) arb_sync <= '0;
        else        arb_sync <= {arb_sync[0], bus.arb_in};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            launch_q    <= 1'b0;
            arb_clr_q   <= 1'b0;
            response_q  <= '0;
            challenge_q <= '0;
            ones        <= '0;
            vote_cnt    <= '0;
            bit_cnt     <= '0;
            settle_cnt  <= '0;
        end else begin
            // Single-cycle strobes; raised only on the transition into their state.
            done_q    <= 1'b0;
            arb_clr_q <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        challenge_q <= bus.seed_challenge;
                        response_q  <= '0;
                        ones        <= '0;
                        vote_cnt    <= '0;
                        bit_cnt     <= '0;
                        busy_q      <= 1'b1;
                        arb_clr_q   <= 1'b1;
                        state       <= ST_CLEAR;
                    end
                end

                ST_CLEAR: begin
                    launch_q <= 1'b1;
                    state    <= ST_LAUNCH;
                end

                ST_LAUNCH: begin
                    settle_cnt <= '0;
                    state      <= ST_SETTLE;
                end

                ST_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        // launch is low from the SAMPLE cycle onwards.
                        launch_q <= 1'b0;
                        state    <= ST_SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end

                ST_SAMPLE: begin
                    ones     <= ones + VW'(arb_sync[1]);
                    vote_cnt <= vote_cnt + 1'b1;
                    if (vote_cnt == VOTE_LAST) begin
                        state <= ST_DECIDE;
                    end else begin
                        arb_clr_q <= 1'b1;
                        state     <= ST_CLEAR;
                    end
                end

                ST_DECIDE: begin
                    // First voted bit ends up in the MSB.
                    response_q <= {response_q[RESP_W-2:0], vote_bit};
                    ones       <= '0;
                    vote_cnt   <= '0;
                    if (bit_cnt == BIT_LAST) begin
                        done_q <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        bit_cnt     <= bit_cnt + 1'b1;
                        // Safe to change: launch is low here.
                        challenge_q <= {challenge_q[CHAL_W-2:0], challenge_q[CHAL_W-1]};
                        arb_clr_q   <= 1'b1;
                        state       <= ST_CLEAR;
                    end
                end

                ST_DONE: begin
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end

                default: begin
                    busy_q   <= 1'b0;
                    launch_q <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.launch    = launch_q;
    assign bus.arb_clr   = arb_clr_q;
    assign bus.response  = response_q;
    assign bus.challenge = challenge_q;

endmodule

// File: tb/tb_puf_response_reader.sv
// -----------------------------------------------------------------------------
// tb_puf_response_reader
//   Directed sequence with randomized vote patterns. The bench plays the PUF
//   fabric: on every arb_clr pulse it presents the next queued vote on arb_in
//   and optionally glitches arb_in outside the launch window. Expected
//   responses, challenges and timing come from a reference model built from
//   the vote queue with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_puf_response_reader;

    localparam int CHAL_W  = 32;
    localparam int RESP_W  = 8;
    localparam int VOTES   = 5;
    localparam int SETTLE  = 4;

    localparam int EVAL_CYC = 3 + SETTLE;
    localparam int BIT_CYC  = VOTES * EVAL_CYC + 1;
    localparam int LATENCY  = RESP_W * BIT_CYC + 1;

    logic clk = 1'b0;
    logic rst_n;

    puf_response_reader_if #(.CHAL_W(CHAL_W), .RESP_W(RESP_W)) bus ();

    puf_response_reader #(
        .CHAL_W(CHAL_W),
        .RESP_W(RESP_W),
        .VOTES (VOTES),
        .SETTLE(SETTLE)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int   n_cmp  = 0;
    int   n_fail = 0;
    logic vq[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CHAL_W-1:0] rotl(input logic [CHAL_W-1:0] s, input int k);
        logic [2*CHAL_W-1:0] w;
        w = {s, s} << k;
        return w[2*CHAL_W-1 -: CHAL_W];
    endfunction

    // Queue five evaluations, first evaluation = MSB of v.
    task automatic push_votes(input logic [VOTES-1:0] v);
        for (int i = VOTES - 1; i >= 0; i--) vq.push_back(v[i]);
    endtask

    // Random votes whose majority equals b.
    task automatic push_bit(input logic b);
        logic [VOTES-1:0] v;
        v = VOTES'($urandom);
        if (($countones(v) * 2 > VOTES) != b) v = ~v;
        push_votes(v);
    endtask

    // start_mode: 0 = one-cycle start, 1 = start held high,
    //             2 = random start pulses while busy, low before DONE.
    // abort_at  : cycle after accept at which rst_n is pulled low (0 = never).
    task automatic run_request(input logic [CHAL_W-1:0] seed, input int start_mode,
                               input int abort_at, input bit glitch);
        int   exp_resp;
        int   c;
        int   pulses, width, vidx, done_cyc;
        bit   busy_ok, width_ok, chal_ok, stable_ok;
        logic prev_launch;
        logic [CHAL_W-1:0] chal_rise;

        exp_resp = 0;
        for (int b = 0; b < RESP_W; b++) begin
            c = 0;
            for (int v = 0; v < VOTES; v++) c += int'(vq[b*VOTES + v]);
            exp_resp = exp_resp * 2 + ((2 * c > VOTES) ? 1 : 0);
        end

        bus.seed_challenge = seed;
        bus.start          = 1'b1;
        @(posedge clk);

        pulses = 0; width = 0; vidx = 0; done_cyc = 0;
        busy_ok = 1; width_ok = 1; chal_ok = 1; stable_ok = 1;
        prev_launch = 1'b0;
        chal_rise   = '0;

        for (int cyc = 1; cyc <= LATENCY + 20 && done_cyc == 0; cyc++) begin
            @(negedge clk);
            case (start_mode)
                1:       bus.start = 1'b1;
                2:       bus.start = (cyc < LATENCY - 1) ? 1'($urandom) : 1'b0;
                default: bus.start = 1'b0;
            endcase

            if (cyc == abort_at) begin
                rst_n = 1'b0;
                #1;
                check("abort_launch",    64'(bus.launch),    64'd0);
                check("abort_arb_clr",   64'(bus.arb_clr),   64'd0);
                check("abort_busy",      64'(bus.busy),      64'd0);
                check("abort_response",  64'(bus.response),  64'd0);
                check("abort_challenge", 64'(bus.challenge), 64'd0);
                vq.delete();
                return;
            end

            if (bus.busy !== 1'b1) busy_ok = 0;

            if (bus.arb_clr === 1'b1) begin
                if (vidx < vq.size()) bus.arb_in = vq[vidx];
                vidx++;
            end else if (glitch && bus.launch !== 1'b1) begin
                bus.arb_in = 1'($urandom);
            end

            if (bus.launch === 1'b1 && !prev_launch) begin
                pulses++;
                width     = 1;
                chal_rise = bus.challenge;
                if (bus.challenge !== rotl(seed, (pulses - 1) / VOTES)) chal_ok = 0;
            end else if (bus.launch === 1'b1) begin
                width++;
                if (bus.challenge !== chal_rise) stable_ok = 0;
            end else if (prev_launch) begin
                if (width != SETTLE + 1) width_ok = 0;
            end
            prev_launch = bus.launch;

            if (bus.done === 1'b1) done_cyc = cyc;
        end

        check("done_latency",     64'(done_cyc),     64'(LATENCY));
        check("response",         64'(bus.response), 64'(exp_resp));
        check("launch_pulses",    64'(pulses),       64'(RESP_W * VOTES));
        check("launch_width",     64'(width_ok),     64'd1);
        check("challenge_value",  64'(chal_ok),      64'd1);
        check("challenge_stable", 64'(stable_ok),    64'd1);
        check("busy_window",      64'(busy_ok),      64'd1);
        check("evaluations",      64'(vidx),         64'(RESP_W * VOTES));
        vq.delete();
    endtask

    // After a completed run: one IDLE cycle, response held, no strobes.
    task automatic check_idle_after(input string tag, input logic [RESP_W-1:0] held);
        @(negedge clk);
        check({tag, "_busy"},     64'(bus.busy),     64'd0);
        check({tag, "_done"},     64'(bus.done),     64'd0);
        check({tag, "_response"}, 64'(bus.response), 64'(held));
    endtask

    initial begin
        logic [RESP_W-1:0] last;
        bit               quiet;

        rst_n              = 1'b0;
        bus.start          = 1'b0;
        bus.seed_challenge = '0;
        bus.arb_in         = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy",      64'(bus.busy),      64'd0);
        check("rst_done",      64'(bus.done),      64'd0);
        check("rst_launch",    64'(bus.launch),    64'd0);
        check("rst_arb_clr",   64'(bus.arb_clr),   64'd0);
        check("rst_response",  64'(bus.response),  64'd0);
        check("rst_challenge", 64'(bus.challenge), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", 64'(bus.busy), 64'd0);

        // All-ones arbiter, no glitches.
        for (int i = 0; i < RESP_W * VOTES; i++) vq.push_back(1'b1);
        run_request(32'hA5A5_A5A5, 0, 0, 0);
        check("ones_response", 64'(bus.response), 64'hFF);
        check_idle_after("ones_idle", 8'hFF);

        // All-zeros arbiter.
        for (int i = 0; i < RESP_W * VOTES; i++) vq.push_back(1'b0);
        run_request(32'h1234_5678, 0, 0, 0);
        check_idle_after("zeros_idle", 8'h00);

        // Majority voting, target 1,0,1,1,0,0,1,0 with glitches outside launch.
        push_votes(5'b11001);
        push_votes(5'b10010);
        push_bit(1'b1); push_bit(1'b1); push_bit(1'b0);
        push_bit(1'b0); push_bit(1'b1); push_bit(1'b0);
        run_request($urandom, 0, 0, 1);
        check("vote_response", 64'(bus.response), 64'hB2);
        check_idle_after("vote_idle", 8'hB2);

        // Walking-one challenge.
        for (int i = 0; i < RESP_W; i++) push_bit(1'($urandom));
        run_request(32'h0000_0001, 0, 0, 1);
        @(negedge clk);

        // Fully random requests.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < RESP_W * VOTES; i++) vq.push_back(1'($urandom));
            run_request($urandom, 0, 0, 1);
            @(negedge clk);
        end

        // start held high: the next run is accepted in the IDLE cycle after DONE.
        for (int i = 0; i < RESP_W; i++) push_bit(1'($urandom));
        run_request($urandom, 1, 0, 1);
        @(negedge clk);
        check("hold_gap_busy", 64'(bus.busy), 64'd0);
        for (int i = 0; i < RESP_W; i++) push_bit(1'($urandom));
        run_request($urandom, 1, 0, 1);
        @(negedge clk);
        check("hold_gap2_busy", 64'(bus.busy), 64'd0);
        // Extra start pulses during the run are ignored.
        for (int i = 0; i < RESP_W; i++) push_bit(1'($urandom));
        run_request($urandom, 2, 0, 1);
        last  = bus.response;
        quiet = 1;
        repeat (4) begin
            @(negedge clk);
            if (bus.busy !== 1'b0 || bus.arb_clr !== 1'b0) quiet = 0;
        end
        check("no_restart", 64'(quiet), 64'd1);
        check("held_response", 64'(bus.response), 64'(last));

        // Reset mid-operation, once during SAMPLE and once during SETTLE.
        for (int a = 0; a < 2; a++) begin
            for (int i = 0; i < RESP_W * VOTES; i++) vq.push_back(1'($urandom));
            run_request($urandom, 0, (a == 0) ? 100 : 97, 1);
            quiet = 1;
            repeat (3) begin
                @(negedge clk);
                if (bus.done !== 1'b0) quiet = 0;
            end
            check("abort_no_done", 64'(quiet), 64'd1);
            rst_n = 1'b1;
            @(negedge clk);
            for (int i = 0; i < RESP_W; i++) push_bit(1'($urandom));
            run_request($urandom, 0, 0, 1);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
